pulse_array: RTL and testbench

//  Output-stationary systolic matrix multiplier: C[MxL] = A[MxN] * B[NxL], unsigned.

---
 rtl/pulse_array_pkg.sv | 22 ++
 rtl/pulse_pe.sv | 68 ++++++
 rtl/pulse_array.sv | 202 ++++++++++++++++++++
 tb/tb_pulse_array.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_array_pkg.sv
// -----------------------------------------------------------------------------
// pulse_array_pkg
// Shared defaults and FSM state type for the pulse_array systolic multiplier.
// -----------------------------------------------------------------------------
package pulse_array_pkg;

    localparam int DEF_WIDTH_LEFT = 4;   // bits per A element
    localparam int DEF_WIDTH_UP   = 4;   // bits per B element
    localparam int DEF_WIDTH_OUT  = 8;   // accumulator / C element width
    localparam int DEF_M          = 3;   // PE rows
    localparam int DEF_N          = 4;   // beats per operation
    localparam int DEF_L          = 3;   // PE columns
    localparam int DEF_LOG2_SIZE  = 10;  // counter width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/pulse_pe.sv
// -----------------------------------------------------------------------------
// pulse_pe
// One multiply-accumulate cell of the systolic grid. The A operand and its
// valid tag move right, the B operand moves down, each through one register.
// Only A carries a tag: the skew network delivers A and B of the same beat to
// a cell on the same edge, so one tag is enough to qualify the pair.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : clear accumulator (wins over a MAC on the same edge)
//   i_a, i_v       : A operand and its valid tag from the left
//   i_b            : B operand from above
//   o_a, o_v, o_b  : registered pass-through to the right / below
//   o_acc          : accumulator, wraps mod 2^WIDTH_out
// -----------------------------------------------------------------------------
module pulse_pe import pulse_array_pkg::*; #(
    parameter int WIDTH_left = DEF_WIDTH_LEFT,
    parameter int WIDTH_up   = DEF_WIDTH_UP,
    parameter int WIDTH_out  = DEF_WIDTH_OUT
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clr,
    input  logic [WIDTH_left-1:0] i_a,
    input  logic                  i_v,
    input  logic [WIDTH_up-1:0]   i_b,
    output logic [WIDTH_left-1:0] o_a,
    output logic                  o_v,
    output logic [WIDTH_up-1:0]   o_b,
    output logic [WIDTH_out-1:0]  o_acc
);

    localparam int PW = WIDTH_left + WIDTH_up;

    logic [WIDTH_left-1:0] r_a;
    logic                  r_v;
    logic [WIDTH_up-1:0]   r_b;
    logic [WIDTH_out-1:0]  r_acc;
    logic [PW-1:0]         w_mul;
    logic [WIDTH_out-1:0]  w_mul_ext;

    // Full-precision product, then zero-extend or truncate to the accumulator.
    assign w_mul     = PW'(i_a) * PW'(i_b);
    assign w_mul_ext = WIDTH_out'(w_mul);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a   <= '0;
            r_v   <= 1'b0;
            r_b   <= '0;
            r_acc <= '0;
        end else begin
            r_a <= i_a;
            r_v <= i_v;
            r_b <= i_b;
            if (i_clr) begin
                r_acc <= '0;
            end else if (i_v) begin
                r_acc <= r_acc + w_mul_ext;
            end
        end
    end

    assign o_a   = r_a;
    assign o_v   = r_v;
    assign o_b   = r_b;
    assign o_acc = r_acc;

endmodule

// File: rtl/pulse_array.sv
// -----------------------------------------------------------------------------
// pulse_array
// Output-stationary systolic multiplier C[MxL] = A[MxN] * B[NxL], unsigned.
// Each accepted beat carries one column of A and one row of B; N beats make
// one product. Inputs are skewed internally, so callers feed plain vectors.
//
// Handshake: there is no back-pressure. A beat is taken on every rising edge
// where valid=1 while the block is in IDLE, LOAD or DONE; valid is ignored in
// DRAIN. ready is a level flag that is 1 only in DONE, while product holds the
// finished result; the next accepted beat drops ready on that same edge.
//
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   valid       : beat strobe
//   left        : A column, slice i = A[i][k]
//   up          : B row,    slice j = B[k][j]
//   ready       : product valid (level)
//   product     : C[i][j] at slice (i*Mritx_L + j)
//   o_dbg_state : current FSM state (debug)
// -----------------------------------------------------------------------------
module pulse_array import pulse_array_pkg::*; #(
    parameter int WIDTH_left      = DEF_WIDTH_LEFT,
    parameter int WIDTH_up        = DEF_WIDTH_UP,
    parameter int WIDTH_out       = DEF_WIDTH_OUT,
    parameter int Mritx_M         = DEF_M,
    parameter int Mritx_N         = DEF_N,
    parameter int Mritx_L         = DEF_L,
    parameter int Mritx_LOG2_size = DEF_LOG2_SIZE
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   valid,
    input  logic [Mritx_M*WIDTH_left-1:0]          left,
    input  logic [Mritx_L*WIDTH_up-1:0]            up,
    output logic                                   ready,
    output logic [Mritx_M*Mritx_L*WIDTH_out-1:0]   product,
    output state_t                                 o_dbg_state
);

    localparam int CW = Mritx_LOG2_size;

    state_t                                 r_state;
    state_t                                 w_next_state;
    logic [CW-1:0]                          r_beat_cnt;
    logic [CW-1:0]                          r_drain_cnt;
    logic [CW-1:0]                          w_beat_idx;
    logic                                   w_accept;
    logic                                   w_first;
    logic                                   w_last_beat;
    logic                                   w_drain_done;
    logic                                   w_clr;
    logic                                   w_snap;
    logic [Mritx_M*Mritx_L*WIDTH_out-1:0]   r_product;
    logic [Mritx_M*Mritx_L*WIDTH_out-1:0]   w_acc_flat;

    // Systolic wiring: column Mritx_L of w_a/w_v and row Mritx_M of w_b are
    // the outputs of the edge cells, which lead nowhere.
    logic [WIDTH_left-1:0] w_a [Mritx_M][Mritx_L+1];
    logic                  w_v [Mritx_M][Mritx_L+1];
    logic [WIDTH_up-1:0]   w_b [Mritx_M+1][Mritx_L];

    // LOAD is left on the last beat, so LOAD never sees an overflow beat.
    assign w_accept     = valid && (r_state != ST_DRAIN);
    assign w_first      = w_accept && (r_state != ST_LOAD);
    assign w_beat_idx   = w_first ? '0 : r_beat_cnt;
    assign w_last_beat  = w_accept && (w_beat_idx == CW'(Mritx_N - 1));
    // The last beat reaches the far corner cell M+L-1 edges after it was taken;
    // the snapshot is taken one edge later, M+L edges after the last beat.
    assign w_drain_done = (r_state == ST_DRAIN) &&
                          (r_drain_cnt == CW'(Mritx_M + Mritx_L - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_next_state = w_last_beat ? ST_DRAIN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_last_beat) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drain_done) begin
                    w_next_state = ST_DONE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready  = (r_state == ST_DONE);
        w_clr  = w_first;
        w_snap = w_drain_done;
    end

    // ---------------- counters and result register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_beat_cnt  <= '0;
            r_drain_cnt <= '0;
            r_product   <= '0;
        end else begin
            if (w_accept) begin
                r_beat_cnt <= w_beat_idx + CW'(1);
            end
            r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + CW'(1) : '0;
            if (w_snap) begin
                r_product <= w_acc_flat;
            end
        end
    end

    assign product     = r_product;
    assign o_dbg_state = r_state;

    // ---------------- input skew ----------------
    // Row i passes through i+1 registers; stage 0 captures the beat on its
    // accept edge and zeros otherwise, so stalls become bubbles in the grid.
    for (genvar i = 0; i < Mritx_M; i++) begin : g_row_skew
        logic [WIDTH_left-1:0] r_sk [0:i];
        logic [i:0]            r_skv;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int s = 0; s <= i; s++) begin
                    r_sk[s] <= '0;
                end
                r_skv <= '0;
            end else begin
                r_sk[0]  <= w_accept ? left[i*WIDTH_left +: WIDTH_left] : '0;
                r_skv[0] <= w_accept;
                for (int s = 1; s <= i; s++) begin
                    r_sk[s]  <= r_sk[s-1];
                    r_skv[s] <= r_skv[s-1];
                end
            end
        end
        assign w_a[i][0] = r_sk[i];
        assign w_v[i][0] = r_skv[i];
    end

    for (genvar j = 0; j < Mritx_L; j++) begin : g_col_skew
        logic [WIDTH_up-1:0] r_sk [0:j];
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int s = 0; s <= j; s++) begin
                    r_sk[s] <= '0;
                end
            end else begin
                r_sk[0] <= w_accept ? up[j*WIDTH_up +: WIDTH_up] : '0;
                for (int s = 1; s <= j; s++) begin
                    r_sk[s] <= r_sk[s-1];
                end
            end
        end
        assign w_b[0][j] = r_sk[j];
    end

    // ---------------- PE grid ----------------
    for (genvar i = 0; i < Mritx_M; i++) begin : g_pe_row
        for (genvar j = 0; j < Mritx_L; j++) begin : g_pe_col
            pulse_pe #(
                .WIDTH_left (WIDTH_left),
                .WIDTH_up   (WIDTH_up),
                .WIDTH_out  (WIDTH_out)
            ) u_pe (
                .i_clk   (clk),
                .i_rst_n (rst),
                .i_clr   (w_clr),
                .i_a     (w_a[i][j]),
                .i_v     (w_v[i][j]),
                .i_b     (w_b[i][j]),
                .o_a     (w_a[i][j+1]),
                .o_v     (w_v[i][j+1]),
                .o_b     (w_b[i+1][j]),
                .o_acc   (w_acc_flat[(i*Mritx_L+j)*WIDTH_out +: WIDTH_out])
            );
        end
        logic w_unused_row_end;
        assign w_unused_row_end = ^{w_a[i][Mritx_L], w_v[i][Mritx_L]};
    end

    for (genvar j = 0; j < Mritx_L; j++) begin : g_col_end
        logic w_unused_col_end;
        assign w_unused_col_end = ^w_b[Mritx_M][j];
    end

endmodule

// File: tb/tb_pulse_array.sv
// -----------------------------------------------------------------------------
// tb_pulse_array
// Directed bench for pulse_array with default parameters (3x4 * 4x3, 8-bit C).
// Edge 0 is the edge that takes beat 0; latency is the index of the first
// edge after which ready reads 1.
// -----------------------------------------------------------------------------
module tb_pulse_array;
    import pulse_array_pkg::*;

    localparam int NBEAT = 4;
    localparam int NUM_C = 9;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        rst;
    logic        valid;
    logic [11:0] left;
    logic [11:0] up;
    logic        ready;
    logic [71:0] product;
    state_t      dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pulse_array dut (
        .clk         (clk),
        .rst         (rst),
        .valid       (valid),
        .left        (left),
        .up          (up),
        .ready       (ready),
        .product     (product),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad   = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_v;
    logic [11:0] beat_left [NBEAT];
    logic [11:0] beat_up   [NBEAT];
    int          lat;
    logic        ready_e0;
    logic [71:0] product_e0;

    // Beat t of a 48-bit table lives in bits [12*t +: 12].
    task automatic load_vectors(input logic [47:0] lv, input logic [47:0] uv);
        for (int t = 0; t < NBEAT; t++) begin
            beat_left[t] = lv[12*t +: 12];
            beat_up[t]   = uv[12*t +: 12];
        end
    endtask

    task automatic push_exp(input int c0, input int c1, input int c2,
                            input int c3, input int c4, input int c5,
                            input int c6, input int c7, input int c8);
        int c[NUM_C];
        c = '{c0, c1, c2, c3, c4, c5, c6, c7, c8};
        foreach (c[x]) exp_q.push_back(8'(c[x]));
    endtask

    // ---------------- driver ----------------
    // gap: one valid=0 cycle between beats; extra: valid held (with junk data)
    // for that many edges after the last beat.
    task automatic run_op(input int gap, input int extra);
        int n;
        n = 0;
        for (int k = 0; k < NBEAT; k++) begin
            valid = 1'b1;
            left  = beat_left[k];
            up    = beat_up[k];
            @(posedge clk); #1; n++;
            if (n == 1) begin
                ready_e0   = ready;
                product_e0 = product;
            end
            if (gap != 0 && k < NBEAT - 1) begin
                valid = 1'b0;
                left  = 12'($urandom_range(0, 4095));
                up    = 12'($urandom_range(0, 4095));
                @(posedge clk); #1; n++;
            end
        end
        for (int e = 0; e < extra; e++) begin
            valid = 1'b1;
            left  = 12'($urandom_range(1, 4095));
            up    = 12'($urandom_range(1, 4095));
            @(posedge clk); #1; n++;
        end
        valid = 1'b0;
        left  = '0;
        up    = '0;
        while (ready !== 1'b1 && n < 60) begin
            @(posedge clk); #1; n++;
        end
        lat = n - 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst   = 1'b0;
        valid = 1'b1;
        left  = 12'hFFF;
        up    = 12'hFFF;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready got=%b exp=0", ready);
        end
        total++;
        if (product !== 72'h0) begin
            bad++; $display("FAIL reset_product got=%h exp=0", product);
        end
        total++;
        if (dbg_state !== ST_IDLE) begin
            bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE);
        end
        valid = 1'b0;
        left  = '0;
        up    = '0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic check_product(input string name, input int exp_lat);
        total++;
        if (lat !== exp_lat) begin
            bad++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, exp_lat);
        end
        total++;
        if (dbg_state !== ST_DONE) begin
            bad++; $display("FAIL %s_state got=%0d exp=%0d", name, dbg_state, ST_DONE);
        end
        for (int idx = 0; idx < NUM_C; idx++) begin
            exp_v = exp_q.pop_front();
            total++;
            if (product[idx*8 +: 8] !== exp_v) begin
                bad++;
                $display("FAIL %s_c[%0d] got=%0d exp=%0d", name, idx, product[idx*8 +: 8], exp_v);
            end
        end
    endtask

    // A = [[1..4],[5..8],[9..12]], B = [I3; 1 1 1], beats k = 3,2,1,0.
    task automatic load_identity();
        load_vectors({12'h951, 12'hA62, 12'hB73, 12'hC84},
                     {12'h001, 12'h010, 12'h100, 12'h111});
    endtask

    task automatic test_identity();
        load_identity();
        push_exp(5, 6, 7, 13, 14, 15, 21, 22, 23);
        run_op(0, 0);
        check_product("identity", 9);
    endtask

    // Starts from DONE of the identity op: ready must drop on beat 0 and
    // product must still show the identity result.
    task automatic test_all_ones();
        load_vectors({4{12'h111}}, {4{12'h111}});
        push_exp(4, 4, 4, 4, 4, 4, 4, 4, 4);
        run_op(0, 0);
        total++;
        if (ready_e0 !== 1'b0) begin
            bad++; $display("FAIL ones_ready_drop got=%b exp=0", ready_e0);
        end
        total++;
        if (product_e0[7:0] !== 8'd5 || product_e0[71:64] !== 8'd23) begin
            bad++; $display("FAIL ones_product_hold got=%h exp c0=5 c8=23", product_e0);
        end
        check_product("ones", 9);
    endtask

    task automatic test_wrap();
        load_vectors({4{12'hFFF}}, {4{12'hFFF}});
        push_exp(132, 132, 132, 132, 132, 132, 132, 132, 132);
        run_op(0, 0);
        check_product("wrap", 9);
    endtask

    task automatic test_gapped();
        load_identity();
        push_exp(5, 6, 7, 13, 14, 15, 21, 22, 23);
        run_op(1, 0);
        check_product("gapped", 12);
    endtask

    task automatic test_extra_beats();
        load_vectors({4{12'h111}}, {4{12'h111}});
        push_exp(4, 4, 4, 4, 4, 4, 4, 4, 4);
        run_op(0, 2);
        check_product("extra", 9);
    endtask

    task automatic test_back_to_back();
        load_identity();
        push_exp(5, 6, 7, 13, 14, 15, 21, 22, 23);
        run_op(0, 0);
        total++;
        if (ready_e0 !== 1'b0) begin
            bad++; $display("FAIL b2b_ready_drop got=%b exp=0", ready_e0);
        end
        total++;
        if (product_e0[7:0] !== 8'd4) begin
            bad++; $display("FAIL b2b_product_hold got=%0d exp=4", product_e0[7:0]);
        end
        check_product("b2b", 9);
    endtask

    task automatic test_reset_drain();
        load_vectors({4{12'h111}}, {4{12'h111}});
        for (int k = 0; k < NBEAT; k++) begin
            valid = 1'b1;
            left  = beat_left[k];
            up    = beat_up[k];
            @(posedge clk); #1;
        end
        valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (dbg_state !== ST_DRAIN) begin
            bad++; $display("FAIL abort_in_drain got=%0d exp=%0d", dbg_state, ST_DRAIN);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if (ready !== 1'b0) begin
            bad++; $display("FAIL abort_ready got=%b exp=0", ready);
        end
        total++;
        if (product !== 72'h0) begin
            bad++; $display("FAIL abort_product got=%h exp=0", product);
        end
        total++;
        if (dbg_state !== ST_IDLE) begin
            bad++; $display("FAIL abort_state got=%0d exp=%0d", dbg_state, ST_IDLE);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        load_vectors({4{12'hFFF}}, {4{12'hFFF}});
        push_exp(132, 132, 132, 132, 132, 132, 132, 132, 132);
        run_op(0, 0);
        check_product("after_abort", 9);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst   = 1'b0;
        valid = 1'b0;
        left  = '0;
        up    = '0;
        test_reset();
        test_identity();
        test_all_ones();
        test_wrap();
        test_gapped();
        test_extra_beats();
        test_back_to_back();
        test_reset_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
